ibr128_ctr_seq: RTL and testbench



---
 rtl/ibr128_ctr_seq.sv | 168 ++++++++++++++++
 tb/tb_ibr128_ctr_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibr128_ctr_seq.sv
// IBR128 CTR-mode counter-block sequencer driving a shared external 8-stage pipelined adder.
// Optional counter-wrap detection is enabled by defining IBR128_CTR_WRAP_DET_EN.
module ibr128_ctr_seq #(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned CALC_CYC = 8
) (
   input  logic             Clk,
   input  logic             RstN,
   input  logic             Start,
   input  logic             Abort,
   input  logic [127:0]     IvIn,
   input  logic [127:0]     StepIn,
   input  logic [CNT_W-1:0] NumBlocks,
   output logic [127:0]     CtrOut,
   output logic             CtrValid,
   input  logic             CtrReady,
   output logic [127:0]     AddA,
   output logic [127:0]     AddB,
   output logic             AddEn,
   input  logic [127:0]     AddS,
   output logic             Busy,
   output logic             Done,
   output logic             WrapErr
);

   localparam int unsigned DW       = 128;
   localparam int unsigned CCW      = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;
   localparam logic [CCW-1:0] CALC_LAST = CCW'(CALC_CYC - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           state_q, state_nxt;
   logic [DW-1:0]    cur_q, step_q, nxt_q;
   logic [CNT_W-1:0] remain_q, remain_dec_c;
   logic [CCW-1:0]   calc_cnt_q;
   logic             valid_q, nxt_valid_q, calc_run_q, cap_pend_q;
   logic             wrap_stop_q, busy_q, done_q;
   logic             hs_c, start_acc_c, slot_free_c, wrap_c;

   assign hs_c         = valid_q & CtrReady;
   assign start_acc_c  = (state_q == ST_IDLE) & Start;
   assign slot_free_c  = ~valid_q | hs_c;
   assign remain_dec_c = hs_c ? (remain_q - CNT_W'(1)) : remain_q;

`ifdef IBR128_CTR_WRAP_DET_EN
   logic wrap_err_q;

   // A sum smaller than its operand means the 128-bit counter rolled over.
   assign wrap_c  = cap_pend_q & (AddS < cur_q);
   assign WrapErr = wrap_err_q;

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN)                               wrap_err_q <= 1'b0;
      else if (start_acc_c)                    wrap_err_q <= 1'b0;
      else if (state_q == ST_RUN && !Abort && wrap_c) wrap_err_q <= 1'b1;
   end
`else
   assign wrap_c  = 1'b0;
   assign WrapErr = 1'b0;
`endif

   // State register plus registered Busy/Done decoded from the next state.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         busy_q  <= (state_nxt != ST_IDLE);
         done_q  <= (state_nxt == ST_DONE);
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (Start) state_nxt = (NumBlocks == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (Abort)                                              state_nxt = ST_IDLE;
            else if (hs_c && (remain_q == CNT_W'(1) || wrap_stop_q)) state_nxt = ST_DONE;
            else if (wrap_c && slot_free_c)                         state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Counter datapath: output slot, prefetch slot and adder sequencing.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         cur_q       <= '0;
         step_q      <= '0;
         nxt_q       <= '0;
         remain_q    <= '0;
         calc_cnt_q  <= '0;
         valid_q     <= 1'b0;
         nxt_valid_q <= 1'b0;
         calc_run_q  <= 1'b0;
         cap_pend_q  <= 1'b0;
         wrap_stop_q <= 1'b0;
      end else if (start_acc_c) begin
         cur_q       <= IvIn;
         step_q      <= StepIn;
         remain_q    <= NumBlocks;
         calc_cnt_q  <= '0;
         valid_q     <= (NumBlocks != '0);
         nxt_valid_q <= 1'b0;
         calc_run_q  <= (NumBlocks > CNT_W'(1));
         cap_pend_q  <= 1'b0;
         wrap_stop_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
         if (Abort) begin
            calc_cnt_q  <= '0;
            valid_q     <= 1'b0;
            nxt_valid_q <= 1'b0;
            calc_run_q  <= 1'b0;
            cap_pend_q  <= 1'b0;
            wrap_stop_q <= 1'b0;
         end else begin
            remain_q   <= remain_dec_c;
            cap_pend_q <= 1'b0;
            if (calc_run_q) begin
               calc_cnt_q <= calc_cnt_q + CCW'(1);
               if (calc_cnt_q == CALC_LAST) begin
                  calc_run_q <= 1'b0;
                  cap_pend_q <= 1'b1;
               end
            end
            // Later assignments below restart the engine whenever cur is reloaded.
            if (wrap_c) begin
               wrap_stop_q <= 1'b1;
               if (slot_free_c) valid_q <= 1'b0;
            end else if (cap_pend_q && slot_free_c) begin
               cur_q   <= AddS;
               valid_q <= 1'b1;
               if (remain_dec_c > CNT_W'(1)) begin
                  calc_run_q <= 1'b1;
                  calc_cnt_q <= '0;
               end
            end else if (cap_pend_q) begin
               nxt_q       <= AddS;
               nxt_valid_q <= 1'b1;
            end else if (hs_c && nxt_valid_q) begin
               cur_q       <= nxt_q;
               nxt_valid_q <= 1'b0;
               if (remain_dec_c > CNT_W'(1)) begin
                  calc_run_q <= 1'b1;
                  calc_cnt_q <= '0;
               end
            end else if (hs_c) begin
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign CtrOut   = cur_q;
   assign CtrValid = valid_q;
   assign AddA     = cur_q;
   assign AddB     = step_q;
   assign AddEn    = calc_run_q;
   assign Busy     = busy_q;
   assign Done     = done_q;

endmodule

// File: tb/tb_ibr128_ctr_seq.sv
// Directed self-checking bench for ibr128_ctr_seq with a behavioural 8-stage adder.
module tb_ibr128_ctr_seq;

   logic         Clk = 1'b0;
   logic         RstN = 1'b0;
   logic         Start = 1'b0;
   logic         Abort = 1'b0;
   logic [127:0] IvIn = '0;
   logic [127:0] StepIn = '0;
   logic [31:0]  NumBlocks = '0;
   logic [127:0] CtrOut;
   logic         CtrValid;
   logic         CtrReady = 1'b0;
   logic [127:0] AddA, AddB, AddS;
   logic         AddEn;
   logic         Busy, Done, WrapErr;

   int total = 0;
   int bad   = 0;

   ibr128_ctr_seq #(.CNT_W(32), .CALC_CYC(8)) dut (
      .Clk(Clk), .RstN(RstN), .Start(Start), .Abort(Abort),
      .IvIn(IvIn), .StepIn(StepIn), .NumBlocks(NumBlocks),
      .CtrOut(CtrOut), .CtrValid(CtrValid), .CtrReady(CtrReady),
      .AddA(AddA), .AddB(AddB), .AddEn(AddEn), .AddS(AddS),
      .Busy(Busy), .Done(Done), .WrapErr(WrapErr)
   );

   always #5 Clk = ~Clk;

   // External adder: sum emerges after eight enabled cycles.
   logic [127:0] pipe [8];
   always @(posedge Clk) begin
      if (AddEn) begin
         pipe[0] <= AddA + AddB;
         for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign AddS = pipe[7];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_run(input logic [127:0] iv, input logic [127:0] st, input logic [31:0] n);
      IvIn = iv; StepIn = st; NumBlocks = n; Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic test_reset();
      RstN = 1'b0;
      tick(); tick();
      total++;
      if (CtrValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || AddEn !== 1'b0 || WrapErr !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got v=%0b b=%0b d=%0b en=%0b w=%0b want all 0", CtrValid, Busy, Done, AddEn, WrapErr);
      end
      total++;
      if (CtrOut !== 128'h0 || AddA !== 128'h0 || AddB !== 128'h0) begin
         bad++;
         $display("FAIL reset_data got out=%0h a=%0h b=%0h want 0", CtrOut, AddA, AddB);
      end
      RstN = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [127:0] e_out;
      logic e_v, e_d, e_en, e_b;
      CtrReady = 1'b1;
      start_run(128'h0, 128'h1, 32'd4);
      for (int c = 1; c <= 30; c++) begin
         e_v   = (c == 1 || c == 10 || c == 19 || c == 28);
         e_out = 128'((c - 1) / 9);
         e_d   = (c == 29);
         e_en  = (c <= 26) && (c % 9 != 0);
         e_b   = (c <= 29);
         total++;
         if (CtrValid !== e_v || (e_v && CtrOut !== e_out)) begin
            bad++;
            $display("FAIL basic_blk c=%0d got v=%0b out=%0h want v=%0b out=%0h", c, CtrValid, CtrOut, e_v, e_out);
         end
         total++;
         if (Done !== e_d || Busy !== e_b) begin
            bad++;
            $display("FAIL basic_done c=%0d got d=%0b b=%0b want d=%0b b=%0b", c, Done, Busy, e_d, e_b);
         end
         total++;
         if (AddEn !== e_en) begin
            bad++;
            $display("FAIL basic_adden c=%0d got %0b want %0b", c, AddEn, e_en);
         end
         tick();
      end
   endtask

   task automatic test_carry();
      logic [127:0] blk [3];
      logic e_v;
      int k;
      blk[0] = 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF;
      blk[1] = 128'h0000FFFF_0000FFFF_0000FFFF_00010000;
      blk[2] = 128'h0000FFFF_0000FFFF_0000FFFF_00010001;
      CtrReady = 1'b1;
      start_run(blk[0], 128'h1, 32'd3);
      for (int c = 1; c <= 21; c++) begin
         e_v = (c == 1 || c == 10 || c == 19);
         k   = (c - 1) / 9;
         total++;
         if (CtrValid !== e_v || (e_v && CtrOut !== blk[k])) begin
            bad++;
            $display("FAIL carry_blk c=%0d got v=%0b out=%0h want v=%0b out=%0h", c, CtrValid, CtrOut, e_v, blk[k]);
         end
         total++;
         if (Done !== (c == 20)) begin
            bad++;
            $display("FAIL carry_done c=%0d got %0b want %0b", c, Done, (c == 20));
         end
         tick();
      end
   endtask

   task automatic test_stall();
      int errs = 0;
      CtrReady = 1'b0;
      start_run(128'h1234, 128'h10, 32'd2);
      for (int c = 1; c <= 30; c++) begin
         total++;
         if (CtrValid !== 1'b1 || CtrOut !== 128'h1234) begin
            bad++; errs++;
            if (errs < 4) $display("FAIL stall_hold c=%0d got v=%0b out=%0h want v=1 out=1234", c, CtrValid, CtrOut);
         end
         tick();
      end
      CtrReady = 1'b1;
      total++;
      if (CtrValid !== 1'b1 || CtrOut !== 128'h1234) begin
         bad++;
         $display("FAIL stall_release got v=%0b out=%0h want v=1 out=1234", CtrValid, CtrOut);
      end
      tick();
      total++;
      if (CtrValid !== 1'b1 || CtrOut !== 128'h1244 || AddEn !== 1'b0) begin
         bad++;
         $display("FAIL stall_prefetch got v=%0b out=%0h en=%0b want v=1 out=1244 en=0", CtrValid, CtrOut, AddEn);
      end
      tick();
      total++;
      if (Done !== 1'b1 || CtrValid !== 1'b0) begin
         bad++;
         $display("FAIL stall_done got d=%0b v=%0b want d=1 v=0", Done, CtrValid);
      end
      tick();
   endtask

   task automatic test_zero();
      CtrReady = 1'b1;
      start_run(128'h77, 128'h1, 32'd0);
      total++;
      if (Done !== 1'b1 || Busy !== 1'b1 || CtrValid !== 1'b0 || AddEn !== 1'b0) begin
         bad++;
         $display("FAIL zero_pulse got d=%0b b=%0b v=%0b en=%0b want 1 1 0 0", Done, Busy, CtrValid, AddEn);
      end
      for (int c = 2; c <= 5; c++) begin
         tick();
         total++;
         if (Done !== 1'b0 || Busy !== 1'b0 || CtrValid !== 1'b0 || AddEn !== 1'b0) begin
            bad++;
            $display("FAIL zero_after c=%0d got d=%0b b=%0b v=%0b en=%0b want 0", c, Done, Busy, CtrValid, AddEn);
         end
      end
   endtask

   task automatic test_abort();
      CtrReady = 1'b0;
      start_run(128'h100, 128'h1, 32'd4);
      tick(); tick(); tick();
      total++;
      if (AddEn !== 1'b1 || CtrValid !== 1'b1 || CtrOut !== 128'h100) begin
         bad++;
         $display("FAIL abort_pre got en=%0b v=%0b out=%0h want 1 1 100", AddEn, CtrValid, CtrOut);
      end
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      total++;
      if (CtrValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || AddEn !== 1'b0) begin
         bad++;
         $display("FAIL abort_post got v=%0b b=%0b d=%0b en=%0b want 0", CtrValid, Busy, Done, AddEn);
      end
      for (int c = 0; c < 12; c++) begin
         tick();
         total++;
         if (Done !== 1'b0 || CtrValid !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet c=%0d got d=%0b v=%0b want 0", c, Done, CtrValid);
         end
      end
      CtrReady = 1'b1;
      start_run(128'h5, 128'h1, 32'd1);
      total++;
      if (CtrValid !== 1'b1 || CtrOut !== 128'h5 || AddEn !== 1'b0) begin
         bad++;
         $display("FAIL abort_restart got v=%0b out=%0h en=%0b want 1 5 0", CtrValid, CtrOut, AddEn);
      end
      tick();
      total++;
      if (Done !== 1'b1 || CtrValid !== 1'b0) begin
         bad++;
         $display("FAIL abort_restart_done got d=%0b v=%0b want d=1 v=0", Done, CtrValid);
      end
      tick();
   endtask

   task automatic test_wrap();
      logic e_v, e_d, e_w;
      logic [127:0] e_out;
      CtrReady = 1'b1;
      start_run({128{1'b1}}, 128'h2, 32'd2);
      for (int c = 1; c <= 12; c++) begin
`ifdef IBR128_CTR_WRAP_DET_EN
         e_v = (c == 1);
         e_d = (c == 10);
         e_w = (c >= 10);
`else
         e_v = (c == 1 || c == 10);
         e_d = (c == 11);
         e_w = 1'b0;
`endif
         e_out = (c == 1) ? {128{1'b1}} : 128'h1;
         total++;
         if (CtrValid !== e_v || (e_v && CtrOut !== e_out)) begin
            bad++;
            $display("FAIL wrap_blk c=%0d got v=%0b out=%0h want v=%0b out=%0h", c, CtrValid, CtrOut, e_v, e_out);
         end
         total++;
         if (Done !== e_d || WrapErr !== e_w) begin
            bad++;
            $display("FAIL wrap_flag c=%0d got d=%0b w=%0b want d=%0b w=%0b", c, Done, WrapErr, e_d, e_w);
         end
         tick();
      end
      start_run(128'h9, 128'h1, 32'd1);
      total++;
      if (WrapErr !== 1'b0 || CtrOut !== 128'h9) begin
         bad++;
         $display("FAIL wrap_clear got w=%0b out=%0h want w=0 out=9", WrapErr, CtrOut);
      end
      tick(); tick();
   endtask

   task automatic test_reset_midrun();
      CtrReady = 1'b0;
      start_run(128'hABC, 128'h1, 32'd4);
      tick(); tick();
      RstN = 1'b0;
      #1;
      total++;
      if (CtrValid !== 1'b0 || Busy !== 1'b0 || AddEn !== 1'b0 || CtrOut !== 128'h0) begin
         bad++;
         $display("FAIL reset_midrun got v=%0b b=%0b en=%0b out=%0h want 0", CtrValid, Busy, AddEn, CtrOut);
      end
      tick();
      RstN = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_stall();
      test_zero();
      test_abort();
      test_wrap();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
